mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage between the execute stage and the write-back stage. It accepts one instruction per handshake and, for memory instructions, waits for the data-SRAM `data_ok` response. It sign- or zero-extends load data and forwards results and exception state to write-back. It also drops responses that belong to requests flushed by a write-back exception.

## Interface
- Parameters: none (widths fixed by shared package).
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high reset.
- `es2ms_valid` in 1: execute stage has an instruction ready.
- `es2ms_bus` in 123: {mem_req 1, ld_op 5 = {b,bu,h,hu,w}, pc 32, except_zip 84, ale 1}.
- `es_rf_zip` in 40: {csr_re, res_from_mem, rf_we, rf_waddr 5, result 32}. `result[1:0]` is the access address low bits.
- `ms_allowin` out 1: stage can latch a new instruction.
- `data_sram_data_ok` in 1: response strobe.
- `data_sram_rdata` in 32: response data.
- `ws_allowin` in 1: write-back can accept.
- `ms2ws_valid` out 1: instruction leaving the stage.
- `ms2ws_bus` out 156: {pc 32, except_zip 84, ale 1, csr_re 1, rf_we 1, rf_waddr 5, rf_wdata 32}.
- `ms_rf_zip` out 40: forwarding bundle {ld_wait, csr_re, rf_we, rf_waddr 5, rf_wdata 32}. Every bit is qualified by `ms_valid`.
- `ms_ex` out 1: the valid instruction in this stage carries an exception.
- `wb_ex` in 1: write-back flush.
- `ms_ld_stall_cnt` out 32: load-stall counter (see Configuration).

## Operation
- Latch `es2ms_bus` and `es_rf_zip` when `es2ms_valid & ms_allowin`.
- `ms_valid` is cleared on `reset` and on `wb_ex`. Otherwise, when `ms_allowin`, it loads `es2ms_valid`.
- Data buffer:
  - Registers `buf_valid` and `buf_data`.
  - A `data_ok` with `ms_valid & mem_req & ~buf_valid & discard_cnt==0` captures `rdata` into the buffer if `~ws_allowin`.
  - The buffer clears when the instruction leaves or on `wb_ex`.
- `ms_ready_go = ~mem_req | buf_valid | (data_ok & discard_cnt==0)`.
- `ms_allowin = ~ms_valid | ms_ready_go & ws_allowin`.
- `ms2ws_valid = ms_valid & ms_ready_go`.
- Load data is `buf_valid ? buf_data : rdata`. Extension:
  - b/bu: byte selected by `addr[1:0]`, sign- or zero-extended.
  - h/hu: half selected by `addr[1]`.
  - w: passthrough.
- `rf_wdata` is the extended load data when `res_from_mem`, else `result`.
- `ld_wait = ms_valid & res_from_mem & ~ms_ready_go`.
- `ms_ex = ms_valid & (|except_zip[5:0] | ale)`. A request with ALE still waits for its `data_ok`.
- Discard counter `discard_cnt` (2 bits, saturates at 2):
  - On `wb_ex`, add 1 if `ms_valid & mem_req & ~buf_valid & ~data_ok`.
  - On `wb_ex`, add a further 1 if `es2ms_valid & es2ms mem_req`, because that request was handshaken this cycle.
  - Each `data_ok` seen while `discard_cnt != 0` decrements it and is ignored.
  - Increment and decrement in the same cycle net out.

## Timing
- Reset values: `ms_valid`=0, `buf_valid`=0, `discard_cnt`=0, `ms_allowin`=1, `ms2ws_valid`=0, `ms_ex`=0, `ms_rf_zip`=0, `ms_ld_stall_cnt`=0.
- Non-memory instruction: resident 1 cycle if `ws_allowin`.
- Memory instruction: `ms2ws_valid` asserts combinationally in the `data_ok` cycle. The earliest case is the cycle after latch.
- If `data_ok` and `~ws_allowin` arrive together, the data is buffered. The instruction leaves on the first subsequent `ws_allowin`.
- `wb_ex` has priority over every latch and capture in the same cycle.

## Configuration
- `MS_LD_STALL_CNT_EN` defined:
  - `ms_ld_stall_cnt` increments every cycle `ld_wait`=1.
  - It wraps at 2^32 and is cleared only by `reset`.
- Not defined: `ms_ld_stall_cnt` is constant 0 and no counter register exists.

## Structure
- Shared package holds:
  - Bus widths (123/40/156) and field offsets.
  - `ld_op` bit indices.
  - `except_zip` flag range [5:0].
- Sub-module `mem_load_ext`: combinational; inputs ld_op 5, addr 2, data 32; output 32.

## Test plan
- ld.b at addr ...3, `rdata`=0x80FF_1234, `data_ok` with `ws_allowin`=1 -> `rf_wdata`=0xFFFF_FF80 in the same cycle. ld.hu at addr ...2 with the same data -> 0x0000_80FF.
- add, result 0x1234 -> `ms2ws_valid` the cycle after latch, `rf_wdata`=0x1234, `ld_wait`=0.
- ld.w, `data_ok` with `ws_allowin`=0 for 3 cycles, `rdata`=0xDEADBEEF -> buffered; leaves when `ws_allowin`=1 with `rf_wdata`=0xDEADBEEF.
- ld.w pending plus new handshake in the `wb_ex` cycle -> `discard_cnt`=2; the next two `data_ok` pulses produce no `ms2ws_valid`; a third load afterwards completes normally.
- ld.w at addr ...1 (ale=1) -> `ms_ex`=1 while valid; it waits for `data_ok`, then forwards `ale`=1.
- With `MS_LD_STALL_CNT_EN`: a load with `data_ok` 4 cycles late -> counter=4. Without the macro -> counter=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared widths, bus layouts and load-op encoding for the memory-access stage.
package mem_stage_pkg;

    localparam int unsigned ES2MS_BUS_W = 123;
    localparam int unsigned ES_RF_ZIP_W = 40;
    localparam int unsigned MS2WS_BUS_W = 156;
    localparam int unsigned MS_RF_ZIP_W = 40;
    localparam int unsigned EXCEPT_W    = 84;
    localparam int unsigned LD_OP_W     = 5;

    // Exception flags that raise ms_ex live in except_zip[EXCEPT_FLAG_HI:EXCEPT_FLAG_LO]
    localparam int unsigned EXCEPT_FLAG_HI = 5;
    localparam int unsigned EXCEPT_FLAG_LO = 0;

    // ld_op = {b, bu, h, hu, w}
    localparam int unsigned LD_B  = 4;
    localparam int unsigned LD_BU = 3;
    localparam int unsigned LD_H  = 2;
    localparam int unsigned LD_HU = 1;
    localparam int unsigned LD_W  = 0;

    typedef struct packed {
        logic                mem_req;
        logic [LD_OP_W-1:0]  ld_op;
        logic [31:0]         pc;
        logic [EXCEPT_W-1:0] except_zip;
        logic                ale;
    } es2ms_bus_t;

    typedef struct packed {
        logic        csr_re;
        logic        res_from_mem;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] result;
    } es_rf_zip_t;

    typedef struct packed {
        logic [31:0]         pc;
        logic [EXCEPT_W-1:0] except_zip;
        logic                ale;
        logic                csr_re;
        logic                rf_we;
        logic [4:0]          rf_waddr;
        logic [31:0]         rf_wdata;
    } ms2ws_bus_t;

    typedef struct packed {
        logic        ld_wait;
        logic        csr_re;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } ms_rf_zip_t;

endpackage

// File: rtl/mem_stage_load_ext.sv
// Load-data alignment and sign/zero extension for byte, half and word loads.
module mem_load_ext
    import mem_stage_pkg::*;
(
    input  logic [LD_OP_W-1:0] ld_op,
    input  logic [1:0]         addr,
    input  logic [31:0]        data,
    output logic [31:0]        ld_result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = data[{addr, 3'b000} +: 8];
        half_sel  = addr[1] ? data[31:16] : data[15:0];
        ld_result = data;
        if (ld_op[LD_B]) begin
            ld_result = {{24{byte_sel[7]}}, byte_sel};
        end else if (ld_op[LD_BU]) begin
            ld_result = {24'h0, byte_sel};
        end else if (ld_op[LD_H]) begin
            ld_result = {{16{half_sel[15]}}, half_sel};
        end else if (ld_op[LD_HU]) begin
            ld_result = {16'h0, half_sel};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for data_ok, extends load data, drops flushed responses.
// Optional load-stall counter is built when MS_LD_STALL_CNT_EN is defined.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   es2ms_valid,
    input  logic [ES2MS_BUS_W-1:0] es2ms_bus,
    input  logic [ES_RF_ZIP_W-1:0] es_rf_zip,
    output logic                   ms_allowin,
    input  logic                   data_sram_data_ok,
    input  logic [31:0]            data_sram_rdata,
    input  logic                   ws_allowin,
    output logic                   ms2ws_valid,
    output logic [MS2WS_BUS_W-1:0] ms2ws_bus,
    output logic [MS_RF_ZIP_W-1:0] ms_rf_zip,
    output logic                   ms_ex,
    input  logic                   wb_ex,
    output logic [31:0]            ms_ld_stall_cnt
);

    es2ms_bus_t  es_bus, ms_bus;
    es_rf_zip_t  es_rf, ms_rf;
    ms2ws_bus_t  out_bus;
    ms_rf_zip_t  fwd_zip;
    logic        ms_valid, ms_ready_go, ld_wait, resp_live;
    logic        buf_valid;
    logic [31:0] buf_data, ld_data, ld_ext, rf_wdata;
    logic [1:0]  discard_cnt, discard_nxt;
    logic [2:0]  discard_sum;

    assign es_bus = es2ms_bus;
    assign es_rf  = es_rf_zip;

    // A data_ok only belongs to this stage once every flushed request has been answered
    assign resp_live   = data_sram_data_ok & (discard_cnt == 2'd0);
    assign ms_ready_go = ~ms_bus.mem_req | buf_valid | resp_live;
    assign ms_allowin  = ~ms_valid | (ms_ready_go & ws_allowin);
    assign ms2ws_valid = ms_valid & ms_ready_go;
    assign ld_wait     = ms_valid & ms_rf.res_from_mem & ~ms_ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
        end else if (wb_ex) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es2ms_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_bus <= '0;
            ms_rf  <= '0;
        end else if (es2ms_valid & ms_allowin & ~wb_ex) begin
            ms_bus <= es_bus;
            ms_rf  <= es_rf;
        end
    end

    always_ff @(posedge clk) begin
        if (reset | wb_ex) begin
            buf_valid <= 1'b0;
            buf_data  <= '0;
        end else if (ms2ws_valid & ws_allowin) begin
            buf_valid <= 1'b0;
        end else if (ms_valid & ms_bus.mem_req & ~buf_valid & resp_live & ~ws_allowin) begin
            buf_valid <= 1'b1;
            buf_data  <= data_sram_rdata;
        end
    end

    // Outstanding requests orphaned by a flush: the one resident here plus one issued this cycle
    always_comb begin
        discard_sum = {1'b0, discard_cnt};
        if (wb_ex) begin
            discard_sum = discard_sum
                        + {2'b00, ms_valid & ms_bus.mem_req & ~buf_valid & ~data_sram_data_ok}
                        + {2'b00, es2ms_valid & es_bus.mem_req};
        end
        if (data_sram_data_ok && discard_cnt != 2'd0) begin
            discard_sum = discard_sum - 3'd1;
        end
        discard_nxt = (discard_sum > 3'd2) ? 2'd2 : discard_sum[1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            discard_cnt <= '0;
        end else begin
            discard_cnt <= discard_nxt;
        end
    end

    assign ld_data = buf_valid ? buf_data : data_sram_rdata;

    mem_load_ext u_load_ext (
        .ld_op     (ms_bus.ld_op),
        .addr      (ms_rf.result[1:0]),
        .data      (ld_data),
        .ld_result (ld_ext)
    );

    assign rf_wdata = ms_rf.res_from_mem ? ld_ext : ms_rf.result;

    always_comb begin
        out_bus.pc         = ms_bus.pc;
        out_bus.except_zip = ms_bus.except_zip;
        out_bus.ale        = ms_bus.ale;
        out_bus.csr_re     = ms_rf.csr_re;
        out_bus.rf_we      = ms_rf.rf_we;
        out_bus.rf_waddr   = ms_rf.rf_waddr;
        out_bus.rf_wdata   = rf_wdata;
        fwd_zip            = '0;
        if (ms_valid) begin
            fwd_zip.ld_wait  = ld_wait;
            fwd_zip.csr_re   = ms_rf.csr_re;
            fwd_zip.rf_we    = ms_rf.rf_we;
            fwd_zip.rf_waddr = ms_rf.rf_waddr;
            fwd_zip.rf_wdata = rf_wdata;
        end
    end

    assign ms2ws_bus = out_bus;
    assign ms_rf_zip = fwd_zip;
    assign ms_ex     = ms_valid & ((|ms_bus.except_zip[EXCEPT_FLAG_HI:EXCEPT_FLAG_LO]) | ms_bus.ale);

`ifdef MS_LD_STALL_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (ld_wait) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign ms_ld_stall_cnt = stall_cnt;
`else
    assign ms_ld_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed corner cases followed by randomized traffic.
`timescale 1ns/1ps
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         es2ms_valid;
    logic [122:0] es2ms_bus;
    logic [39:0]  es_rf_zip;
    logic         ms_allowin;
    logic         data_ok;
    logic [31:0]  rdata;
    logic         ws_allowin;
    logic         ms2ws_valid;
    logic [155:0] ms2ws_bus;
    logic [39:0]  ms_rf_zip;
    logic         ms_ex;
    logic         wb_ex;
    logic [31:0]  ms_ld_stall_cnt;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .es2ms_valid       (es2ms_valid),
        .es2ms_bus         (es2ms_bus),
        .es_rf_zip         (es_rf_zip),
        .ms_allowin        (ms_allowin),
        .data_sram_data_ok (data_ok),
        .data_sram_rdata   (rdata),
        .ws_allowin        (ws_allowin),
        .ms2ws_valid       (ms2ws_valid),
        .ms2ws_bus         (ms2ws_bus),
        .ms_rf_zip         (ms_rf_zip),
        .ms_ex             (ms_ex),
        .wb_ex             (wb_ex),
        .ms_ld_stall_cnt   (ms_ld_stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [83:0] exc;
        logic        ale;
        logic        csr_re;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] resp_q[$];
    int          checks = 0;
    int          fails  = 0;
    bit          resp_en = 1'b0;
    bit          ws_rand = 1'b0;

    // op codes used by the bench: 0=b 1=bu 2=h 3=hu 4=w
    function automatic logic [4:0] op_onehot(input int op);
        logic [4:0] top;
        top = 5'b10000;
        return top >> op;
    endfunction

    function automatic logic [31:0] ref_load(input int op, input int unsigned addr, input logic [31:0] data);
        longint d;
        longint v;
        d = longint'(data);
        case (op)
            0: begin v = (d >> (8 * addr)) % 256; if (v >= 128) v = v - 256; end
            1: v = (d >> (8 * addr)) % 256;
            2: begin v = (d >> (16 * (addr / 2))) % 65536; if (v >= 32768) v = v - 65536; end
            3: v = (d >> (16 * (addr / 2))) % 65536;
            default: v = d;
        endcase
        return v[31:0];
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Present one instruction, wait for the handshake, record its expected write-back result
    task automatic send(input bit mem, input int op, input logic [31:0] pc, input logic [83:0] exc,
                        input bit ale, input bit csr, input bit from_mem, input bit we,
                        input logic [4:0] wa, input logic [31:0] result, input logic [31:0] rd,
                        input bit expect_out);
        bit          got;
        exp_t        e;
        logic [127:0] g;
        got = 1'b0;
        es2ms_valid = 1'b1;
        es2ms_bus   = {mem, op_onehot(op), pc, exc, ale};
        es_rf_zip   = {csr, from_mem, we, wa, result};
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            got = ms_allowin;
            @(posedge clk);
        end
        if (!got) begin
            check("handshake_timeout", 0, 1);
        end else begin
            e.pc = pc; e.exc = exc; e.ale = ale; e.csr_re = csr; e.rf_we = we; e.waddr = wa;
            e.wdata = from_mem ? ref_load(op, int'(result[1:0]), rd) : result;
            if (expect_out) exp_q.push_back(e);
            if (mem && resp_en) resp_q.push_back(rd);
        end
        #1;
        g = {$urandom, $urandom, $urandom, $urandom};
        es2ms_valid = 1'b0;
        es2ms_bus   = {1'b0, g[121:0]};
        es_rf_zip   = g[39:0];
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ws_rand) ws_allowin = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (resp_en) begin
                if (data_ok && resp_q.size() > 0) void'(resp_q.pop_front());
                if (resp_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                    data_ok = 1'b1;
                    rdata   = resp_q[0];
                end else begin
                    data_ok = 1'b0;
                    rdata   = $urandom;
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && ms2ws_valid && ws_allowin) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_output: got pc 0x%0h wdata 0x%0h, required no output",
                             ms2ws_bus[155:124], ms2ws_bus[31:0]);
                end else begin
                    e = exp_q.pop_front();
                    check("out_pc",    ms2ws_bus[155:124], e.pc);
                    check("out_exc",   ms2ws_bus[123:40],  e.exc);
                    check("out_ale",   ms2ws_bus[39],      e.ale);
                    check("out_csr",   ms2ws_bus[38],      e.csr_re);
                    check("out_we",    ms2ws_bus[37],      e.rf_we);
                    check("out_waddr", ms2ws_bus[36:32],   e.waddr);
                    check("out_wdata", ms2ws_bus[31:0],    e.wdata);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", fails);
        $fatal(1);
    end

    initial begin
        logic [31:0] cnt0;
        int unsigned stall_exp;
        reset = 1'b1; es2ms_valid = 1'b0; es2ms_bus = '0; es_rf_zip = '0;
        data_ok = 1'b0; rdata = '0; ws_allowin = 1'b1; wb_ex = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_allowin",  ms_allowin,      1);
        check("rst_valid",    ms2ws_valid,     0);
        check("rst_ms_ex",    ms_ex,           0);
        check("rst_rf_zip",   ms_rf_zip,       0);
        check("rst_stallcnt", ms_ld_stall_cnt, 0);
        step;
        reset = 1'b0;

        // non-memory instruction leaves the cycle after latch
        send(0, 4, 32'h1000, '0, 0, 0, 0, 1, 5'd3, 32'h1234, 0, 1);
        @(negedge clk);
        check("add_valid",   ms2ws_valid,      1);
        check("add_wdata",   ms_rf_zip[31:0],  32'h1234);
        check("add_ld_wait", ms_rf_zip[39],    0);
        check("add_ms_ex",   ms_ex,            0);
        step;

        // ld.b at byte 3, response in the cycle after latch
        send(1, 0, 32'h1004, '0, 0, 0, 1, 1, 5'd4, 32'h2003, 32'h80FF1234, 1);
        data_ok = 1'b1; rdata = 32'h80FF1234;
        @(negedge clk);
        check("ldb_valid", ms2ws_valid,     1);
        check("ldb_wdata", ms_rf_zip[31:0], 32'hFFFFFF80);
        step;
        data_ok = 1'b0;

        // ld.hu at half 1, one cycle of waiting first
        send(1, 3, 32'h1008, '0, 0, 0, 1, 1, 5'd5, 32'h2002, 32'h80FF1234, 1);
        @(negedge clk);
        check("ldhu_ld_wait", ms_rf_zip[39], 1);
        check("ldhu_waiting", ms2ws_valid,   0);
        check("ldhu_allowin", ms_allowin,    0);
        step;
        data_ok = 1'b1; rdata = 32'h80FF1234;
        @(negedge clk);
        check("ldhu_wdata", ms_rf_zip[31:0], 32'h000080FF);
        step;
        data_ok = 1'b0;

        // ld.w answered while write-back is stalled: must come from the buffer
        send(1, 4, 32'h100C, '0, 0, 0, 1, 1, 5'd6, 32'h3000, 32'hDEADBEEF, 1);
        ws_allowin = 1'b0; data_ok = 1'b1; rdata = 32'hDEADBEEF;
        @(negedge clk);
        check("buf_resp_valid", ms2ws_valid, 1);
        step;
        data_ok = 1'b0; rdata = 32'h0;
        @(negedge clk);
        check("buf_hold_valid",   ms2ws_valid,     1);
        check("buf_hold_allowin", ms_allowin,      0);
        check("buf_hold_wdata",   ms_rf_zip[31:0], 32'hDEADBEEF);
        step;
        @(negedge clk);
        check("buf_hold2_valid", ms2ws_valid, 1);
        step;
        ws_allowin = 1'b1;
        @(negedge clk);
        check("buf_leave_valid", ms2ws_valid, 1);
        step;

        // misaligned ld.w: exception visible immediately, still waits for its response
        send(1, 4, 32'h1010, '0, 1, 0, 1, 1, 5'd7, 32'h3001, 32'h55AA55AA, 1);
        @(negedge clk);
        check("ale_ms_ex",  ms_ex,       1);
        check("ale_waits",  ms2ws_valid, 0);
        step;
        data_ok = 1'b1; rdata = 32'h55AA55AA;
        @(negedge clk);
        check("ale_leave_valid", ms2ws_valid, 1);
        check("ale_leave_ms_ex", ms_ex,       1);
        step;
        data_ok = 1'b0;
        @(negedge clk);
        check("ale_gone_ms_ex", ms_ex, 0);
        step;

        // exception flag range edges: bit 3 flags, bit 6 does not
        send(0, 4, 32'h1014, 84'h8, 0, 1, 0, 0, 5'd8, 32'h7, 0, 1);
        @(negedge clk);
        check("exc3_ms_ex", ms_ex, 1);
        step;
        send(0, 4, 32'h1018, 84'h40, 0, 0, 0, 1, 5'd9, 32'h8, 0, 1);
        @(negedge clk);
        check("exc6_ms_ex", ms_ex, 0);
        step;

        // load stalled for four cycles
        cnt0 = ms_ld_stall_cnt;
        send(1, 4, 32'h101C, '0, 0, 0, 1, 1, 5'd10, 32'h4000, 32'h0BADF00D, 1);
        repeat (4) step;
        data_ok = 1'b1; rdata = 32'h0BADF00D;
        step;
        data_ok = 1'b0;
        @(negedge clk);
`ifdef MS_LD_STALL_CNT_EN
        stall_exp = 4;
`else
        stall_exp = 0;
`endif
        check("stall_cnt_delta", ms_ld_stall_cnt - cnt0, stall_exp);
        step;

        // flush with one request pending here and one issued in the same cycle
        send(1, 4, 32'h1020, '0, 0, 0, 1, 1, 5'd11, 32'h5000, 32'h0, 0);
        wb_ex = 1'b1;
        es2ms_valid = 1'b1;
        es2ms_bus   = {1'b1, op_onehot(4), 32'h1024, 84'h0, 1'b0};
        es_rf_zip   = {1'b0, 1'b1, 1'b1, 5'd12, 32'h5004};
        step;
        wb_ex = 1'b0; es2ms_valid = 1'b0;
        @(negedge clk);
        check("flush_valid",   ms2ws_valid, 0);
        check("flush_allowin", ms_allowin,  1);
        step;
        data_ok = 1'b1; rdata = 32'h22222222;
        @(negedge clk);
        check("disc1_no_out", ms2ws_valid, 0);
        step;
        data_ok = 1'b0;
        send(1, 4, 32'h1028, '0, 0, 0, 1, 1, 5'd13, 32'h6000, 32'hCAFEF00D, 1);
        data_ok = 1'b1; rdata = 32'h11111111;
        @(negedge clk);
        check("disc2_no_out",  ms2ws_valid,   0);
        check("disc2_ld_wait", ms_rf_zip[39], 1);
        step;
        data_ok = 1'b1; rdata = 32'hCAFEF00D;
        @(negedge clk);
        check("post_disc_valid", ms2ws_valid, 1);
        step;
        data_ok = 1'b0;

        // randomized traffic against the reference model
        resp_en = 1'b1;
        ws_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bit          mem, from_mem;
            int          op;
            logic [95:0] ex;
            mem      = $urandom_range(0, 1) == 1;
            from_mem = mem && ($urandom_range(0, 3) != 0);
            op       = $urandom_range(0, 4);
            ex       = {$urandom, $urandom, $urandom};
            if ($urandom_range(0, 3) != 0) ex = '0;
            send(mem, op, $urandom, ex[83:0], 1'b0, $urandom_range(0, 1) == 1, from_mem,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom, $urandom, 1);
            if ($urandom_range(0, 3) == 0) step;
        end
        for (int n = 0; n < 1000 && exp_q.size() != 0; n++) step;
        check("drain_pending", exp_q.size(), 0);
        resp_en = 1'b0;
        ws_rand = 1'b0;
        data_ok = 1'b0;
        ws_allowin = 1'b1;
        step;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
